// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the pipelined 64-bit core.
//   - PC_INIT      : default PC loaded on reset
//   - NOP_INSTR    : encoding used for IF/ID bubbles
//   - opcode_t     : major opcode classes used by decode
//   - fetch_state_t: IF stage state machine encoding (BOOT/FETCH/HOLD)
//   - add          : 64-bit unsigned adder shared by the PC and ALU paths;
//                    the result wraps modulo 2^64
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [63:0] PC_INIT   = 64'h0;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_SYS    = 3'd5,
        OP_NOP    = 3'd6
    } opcode_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [63:0] add(input logic [63:0] a, input logic [63:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     pc         in  64 : current fetch PC
//     br_taken   in   1 : taken branch this cycle (already gated by stall)
//     br_target  in  64 : branch target from decode
//     redir_pend in   1 : a redirect was stored while a request was in flight
//     redir_tgt  in  64 : the stored redirect target
//     pc_next    out 64 : selected next PC
//   A fresh branch wins over a stored one, since it is the newer decision.
// ----------------------------------------------------------------------------
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [63:0] pc,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        redir_pend,
    input  logic [63:0] redir_tgt,
    output logic [63:0] pc_next
);

    logic [63:0] pc_plus4;

    assign pc_plus4 = add(pc, 64'd4);

    always_comb begin
        pc_next = pc_plus4;
        if (br_taken) begin
            pc_next = br_target;
        end else if (redir_pend) begin
            pc_next = redir_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// ----------------------------------------------------------------------------
// instr_fetch_stage
//   IF stage: owns the PC, requests instructions from instruction memory and
//   loads the IF/ID register. One skid entry absorbs a word that returns while
//   decode is stalled.
//
//   Parameters:
//     PC_INIT        : PC loaded on reset
//   Ports:
//     clk            in   1 : clock, rising edge
//     rst_n          in   1 : synchronous active-low reset
//     stall          in   1 : decode held; IF/ID and PC do not advance
//     br_taken       in   1 : taken branch resolved by decode
//     br_target      in  64 : branch target
//     imem_req       out  1 : fetch request valid
//     imem_addr      out 64 : fetch address
//     imem_ready     in   1 : memory returns imem_data this cycle
//     imem_data      in  32 : instruction word
//     if_id_valid    out  1 : IF/ID holds a real instruction
//     if_id_instr    out 32 : instruction to decode
//     if_id_pc       out 64 : PC of if_id_instr
//     fetch_count    out 32 : valid IF/ID loads, wraps modulo 2^32
//     state_dbg      out  2 : current fetch state
//
//   Memory handshake: a word transfers on any cycle where imem_req and
//   imem_ready are both high (zero-wait return is legal). While imem_req is
//   high and imem_ready low, imem_addr is held constant. Dropping imem_req
//   (reset) abandons the outstanding request.
//
//   Build option FETCH_DELAY_SLOT_EN: when defined, the word fetched right
//   after a taken branch (the delay slot) is delivered as a valid
//   instruction; otherwise it is squashed into a bubble and not counted.
// ----------------------------------------------------------------------------
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] PC_INIT = cpu_pkg::PC_INIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         br_taken,
    input  logic [63:0]  br_target,
    output logic         imem_req,
    output logic [63:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_data,
    output logic         if_id_valid,
    output logic [31:0]  if_id_instr,
    output logic [63:0]  if_id_pc,
    output logic [31:0]  fetch_count,
    output fetch_state_t state_dbg
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam logic DS_KEEP = 1'b1;
`else
    localparam logic DS_KEEP = 1'b0;
`endif

    fetch_state_t state, state_nxt;
    logic [63:0]  pc, pc_nxt, pc_sel;
    logic         redir_pend, redir_pend_nxt;
    logic [63:0]  redir_tgt, redir_tgt_nxt;
    logic         skid_valid, skid_valid_nxt;
    logic [31:0]  skid_instr, skid_instr_nxt;
    logic [63:0]  skid_pc, skid_pc_nxt;
    logic         if_id_valid_nxt;
    logic [31:0]  if_id_instr_nxt;
    logic [63:0]  if_id_pc_nxt;
    logic [31:0]  fetch_count_nxt;
    logic         if_id_load;

    logic br_eff;     // branch honoured this cycle (stall has priority)
    logic accept;     // word transferred from memory this cycle
    logic is_ds;      // the accepted word is the delay slot of a taken branch
    logic keep_word;  // accepted word goes on to decode as a valid instruction

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign state_dbg = state;

    assign br_eff    = br_taken & ~stall;
    assign accept    = imem_req & imem_ready;
    // Pending redirect means no word was accepted since the branch, so the
    // next accepted word is its delay slot.
    assign is_ds     = accept & (br_eff | redir_pend);
    assign keep_word = ~is_ds | DS_KEEP;

    pc_next_sel u_pc_next_sel (
        .pc         (pc),
        .br_taken   (br_eff),
        .br_target  (br_target),
        .redir_pend (redir_pend),
        .redir_tgt  (redir_tgt),
        .pc_next    (pc_sel)
    );

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        redir_pend_nxt  = redir_pend;
        redir_tgt_nxt   = redir_tgt;
        skid_valid_nxt  = skid_valid;
        skid_instr_nxt  = skid_instr;
        skid_pc_nxt     = skid_pc;
        if_id_load      = 1'b0;
        if_id_valid_nxt = if_id_valid;
        if_id_instr_nxt = if_id_instr;
        if_id_pc_nxt    = if_id_pc;

        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (accept) begin
                    pc_nxt         = pc_sel;
                    redir_pend_nxt = 1'b0;
                    if (stall) begin
                        skid_valid_nxt = keep_word;
                        skid_instr_nxt = imem_data;
                        skid_pc_nxt    = pc;
                        state_nxt      = HOLD;
                    end else begin
                        if_id_load      = 1'b1;
                        if_id_valid_nxt = keep_word;
                        // A squashed word becomes a bubble that keeps the old PC.
                        if_id_instr_nxt = keep_word ? imem_data : NOP_INSTR;
                        if_id_pc_nxt    = keep_word ? pc : if_id_pc;
                    end
                end else if (!stall) begin
                    if_id_load      = 1'b1;
                    if_id_valid_nxt = 1'b0;
                    if_id_instr_nxt = NOP_INSTR;
                end
            end
            HOLD: begin
                if (!stall) begin
                    if_id_load      = 1'b1;
                    if_id_valid_nxt = skid_valid;
                    if_id_instr_nxt = skid_valid ? skid_instr : NOP_INSTR;
                    if_id_pc_nxt    = skid_valid ? skid_pc : if_id_pc;
                    state_nxt       = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase

        // A branch that cannot steer the PC yet is remembered until the
        // in-flight (or next) word arrives; the address meanwhile stays put.
        if (br_eff && !accept) begin
            redir_pend_nxt = 1'b1;
            redir_tgt_nxt  = br_target;
        end

        fetch_count_nxt = fetch_count;
        if (if_id_load && if_id_valid_nxt) begin
            fetch_count_nxt = fetch_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= PC_INIT;
            redir_pend  <= 1'b0;
            redir_tgt   <= 64'd0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 64'd0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 64'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            redir_pend  <= redir_pend_nxt;
            redir_tgt   <= redir_tgt_nxt;
            skid_valid  <= skid_valid_nxt;
            skid_instr  <= skid_instr_nxt;
            skid_pc     <= skid_pc_nxt;
            if_id_valid <= if_id_valid_nxt;
            if_id_instr <= if_id_instr_nxt;
            if_id_pc    <= if_id_pc_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_stage
//   Directed bench for instr_fetch_stage. Instruction memory returns the low
//   32 bits of the address as the instruction word, so every valid IF/ID
//   entry must carry instr == pc[31:0]. Expectations for the delay-slot word
//   follow FETCH_DELAY_SLOT_EN as seen by this file.
// ----------------------------------------------------------------------------
module tb_instr_fetch_stage;
    import cpu_pkg::*;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         br_taken;
    logic [63:0]  br_target;
    logic         imem_req;
    logic [63:0]  imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_data;
    logic         if_id_valid;
    logic [31:0]  if_id_instr;
    logic [63:0]  if_id_pc;
    logic [31:0]  fetch_count;
    fetch_state_t state_dbg;

    always #5 clk = ~clk;

    assign imem_data = imem_addr[31:0];

    instr_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .fetch_count (fetch_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare all observable outputs against one expected snapshot.
    task automatic chk_all(input string tag, input logic ev, input logic [63:0] epc,
                           input logic ereq, input logic [63:0] eaddr,
                           input logic [31:0] ecnt, input fetch_state_t est);
        logic [31:0] einstr;
        einstr = ev ? epc[31:0] : NOP_INSTR;
        chk({tag, "_valid"}, 64'(if_id_valid), 64'(ev));
        chk({tag, "_instr"}, 64'(if_id_instr), 64'(einstr));
        chk({tag, "_pc"},    if_id_pc, epc);
        chk({tag, "_req"},   64'(imem_req), 64'(ereq));
        chk({tag, "_addr"},  imem_addr, eaddr);
        chk({tag, "_cnt"},   64'(fetch_count), 64'(ecnt));
        chk({tag, "_state"}, 64'(state_dbg), 64'(est));
    endtask

    task automatic chk_reset(input string tag);
        chk_all(tag, 1'b0, 64'd0, 1'b0, PC_INIT, 32'd0, BOOT);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic b, input logic [63:0] t, input logic r);
        @(negedge clk);
        stall      = s;
        br_taken   = b;
        br_target  = t;
        imem_ready = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         stall;
        logic         br;
        logic [63:0]  tgt;
        logic         ready;
        logic         ev;
        logic [63:0]  epc;
        logic         ereq;
        logic [63:0]  eaddr;
        logic [31:0]  ecnt;
        fetch_state_t est;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic s, input logic b, input logic [63:0] t, input logic r,
                     input logic ev, input logic [63:0] epc, input logic ereq,
                     input logic [63:0] eaddr, input logic [31:0] ecnt, input fetch_state_t est);
        vec_t e;
        e.stall = s;  e.br = b;     e.tgt = t;     e.ready = r;
        e.ev = ev;    e.epc = epc;  e.ereq = ereq; e.eaddr = eaddr;
        e.ecnt = ecnt; e.est = est;
        vecs.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 64'd0; imem_ready = 1'b0;

        // Inputs applied for one cycle -> outputs after the following edge.
        // Zero-wait run from reset
        v(0,0,64'h0,1,   0,   64'h0,   1, 64'h0,   0, FETCH);  // BOOT -> FETCH
        v(0,0,64'h0,1,   1,   64'h0,   1, 64'h4,   1, FETCH);
        v(0,0,64'h0,1,   1,   64'h4,   1, 64'h8,   2, FETCH);
        // Stall 3 cycles with pc=8 returned: skid holds 8, IF/ID keeps 4
        v(1,0,64'h0,1,   1,   64'h4,   0, 64'hC,   2, HOLD);
        v(1,0,64'h0,1,   1,   64'h4,   0, 64'hC,   2, HOLD);
        v(1,0,64'h0,1,   1,   64'h4,   0, 64'hC,   2, HOLD);
        v(0,0,64'h0,1,   1,   64'h8,   1, 64'hC,   3, FETCH);
        // Branch to 0x100 with IF/ID pc=8: word 12 is the delay slot
        v(0,1,64'h100,1, DS,  DS ? 64'hC : 64'h8, 1, 64'h100, DS ? 4 : 3, FETCH);
        v(0,0,64'h0,1,   1,   64'h100, 1, 64'h104, DS ? 5 : 4, FETCH);
        v(0,0,64'h0,1,   1,   64'h104, 1, 64'h108, DS ? 6 : 5, FETCH);
        // Branch while memory is not ready for two cycles
        v(0,1,64'h200,0, 0,   64'h104, 1, 64'h108, DS ? 6 : 5, FETCH);
        v(0,0,64'h0,0,   0,   64'h104, 1, 64'h108, DS ? 6 : 5, FETCH);
        v(0,0,64'h0,1,   DS,  DS ? 64'h108 : 64'h104, 1, 64'h200, DS ? 7 : 5, FETCH);
        v(0,0,64'h0,1,   1,   64'h200, 1, 64'h204, DS ? 8 : 6, FETCH);
        // Branch under stall is ignored
        v(1,1,64'h300,0, 1,   64'h200, 1, 64'h204, DS ? 8 : 6, FETCH);
        v(0,0,64'h0,1,   1,   64'h204, 1, 64'h208, DS ? 9 : 7, FETCH);
        // Pending redirect whose delay slot lands in the skid buffer
        v(0,1,64'h400,0, 0,   64'h204, 1, 64'h208, DS ? 9 : 7, FETCH);
        v(1,0,64'h0,1,   0,   64'h204, 0, 64'h400, DS ? 9 : 7, HOLD);
        v(0,0,64'h0,1,   DS,  DS ? 64'h208 : 64'h204, 1, 64'h400, DS ? 10 : 7, FETCH);
        v(0,0,64'h0,1,   1,   64'h400, 1, 64'h404, DS ? 11 : 8, FETCH);
        // PC wraps at 2^64
        v(0,1,64'hFFFF_FFFF_FFFF_FFFC,1, DS, DS ? 64'h404 : 64'h400, 1,
          64'hFFFF_FFFF_FFFF_FFFC, DS ? 12 : 8, FETCH);
        v(0,0,64'h0,1,   1,   64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0, DS ? 13 : 9, FETCH);
        v(0,0,64'h0,1,   1,   64'h0,   1, 64'h4,   DS ? 14 : 10, FETCH);

        // Reset
        step(0, 0, 64'h0, 0);
        step(0, 0, 64'h0, 0);
        chk_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ready);
            chk_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ereq,
                    vecs[i].eaddr, vecs[i].ecnt, vecs[i].est);
        end

        // Reset while in HOLD
        step(1, 0, 64'h0, 1);
        chk("hold_state", 64'(state_dbg), 64'(HOLD));
        rst_n = 1'b0;
        step(1, 0, 64'h0, 1);
        chk_reset("rst_hold");
        rst_n = 1'b1;
        step(0, 0, 64'h0, 1);
        chk_all("rs1_boot", 0, 64'h0, 1, 64'h0, 0, FETCH);
        step(0, 0, 64'h0, 1);
        chk_all("rs1_first", 1, 64'h0, 1, 64'h4, 1, FETCH);

        // Reset with a redirect pending; restart must not use the old target
        step(0, 1, 64'h500, 0);
        chk_all("pend", 0, 64'h0, 1, 64'h4, 1, FETCH);
        rst_n = 1'b0;
        step(0, 0, 64'h0, 1);
        chk_reset("rst_pend");
        rst_n = 1'b1;
        step(0, 0, 64'h0, 1);
        chk_all("rs2_boot", 0, 64'h0, 1, 64'h0, 0, FETCH);
        step(0, 0, 64'h0, 1);
        chk_all("rs2_first", 1, 64'h0, 1, 64'h4, 1, FETCH);
        step(0, 0, 64'h0, 1);
        chk_all("rs2_second", 1, 64'h4, 1, 64'h8, 2, FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
